// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin arbiter driving a shared 16-bit 4:1 mux onto a registered bus
//
// mux16_4x1 : combinational 16-bit 4:1 word mux
//   sel             select index
//   i0..i3          candidate words
//   y               selected word
//
// mux16_rr_arbiter : four-requester round-robin arbiter with registered bus
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   req[3:0]        request per source
//   I0..I3          source words, only observed through the internal mux
//   grant[3:0]      registered one-hot grant, 0000 when idle
//   A1, A0          registered mux select, index of the granted source
//   Q[15:0]         registered shared-bus word
//   valid           Q was captured on the last edge

module mux16_4x1 (
    input  logic [1:0]  sel,
    input  logic [15:0] i0,
    input  logic [15:0] i1,
    input  logic [15:0] i2,
    input  logic [15:0] i3,
    output logic [15:0] y
);
    always_comb begin
        y = i0;
        case (sel)
            2'd0: y = i0;
            2'd1: y = i1;
            2'd2: y = i2;
            2'd3: y = i3;
            default: y = i0;
        endcase
    end
endmodule

module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] I0,
    input  logic [15:0] I1,
    input  logic [15:0] I2,
    input  logic [15:0] I3,
    output logic [3:0]  grant,
    output logic        A0,
    output logic        A1,
    output logic [15:0] Q,
    output logic        valid
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [3:0]        r_grant;
    logic [1:0]        r_sel;
    logic [15:0]       r_q;
    logic              r_valid;
    logic [HOLD_W-1:0] r_hold;
    logic [1:0]        r_last;

    logic [3:0]        w_nxt_grant;
    logic [1:0]        w_nxt_sel;
    logic [HOLD_W-1:0] w_nxt_hold;
    logic [1:0]        w_nxt_last;

    logic              w_own;
    logic              w_cur_req;
    logic [1:0]        w_start;
    logic [3:0]        w_cand;
    logic              w_found;
    logic [1:0]        w_idx;
    logic [15:0]       w_mux_y;
    logic              w_capture;

    // The mux is steered by the registered select, so Q never sees a
    // combinational path from req.
    mux16_4x1 u_mux (
        .sel (r_sel),
        .i0  (I0),
        .i1  (I1),
        .i2  (I2),
        .i3  (I3),
        .y   (w_mux_y)
    );

    assign w_own     = |r_grant;
    assign w_cur_req = req[r_sel];

    // While owning, the current owner is masked out so the same search
    // serves both the forced handoff (owner still requesting) and the
    // release case (owner's req already low). When idle the search resumes
    // after the last owner.
    assign w_start = w_own ? (r_sel + 2'd1) : (r_last + 2'd1);
    assign w_cand  = w_own ? (req & ~(4'b0001 << r_sel)) : req;

    always_comb begin : rr_search
        logic [1:0] v_probe;
        w_found = 1'b0;
        w_idx   = 2'd0;
        v_probe = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v_probe = w_start + 2'(i);
            if (!w_found && w_cand[v_probe]) begin
                w_found = 1'b1;
                w_idx   = v_probe;
            end
        end
    end

    // State register: grant/select/hold/last_ptr; IDLE vs OWN is grant==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_hold  <= '0;
            r_last  <= 2'd3;
        end else begin
            r_grant <= w_nxt_grant;
            r_sel   <= w_nxt_sel;
            r_hold  <= w_nxt_hold;
            r_last  <= w_nxt_last;
        end
    end

    // Next-state decision.
    always_comb begin
        w_nxt_grant = r_grant;
        w_nxt_sel   = r_sel;
        w_nxt_hold  = '0;
        w_nxt_last  = r_last;
        if (w_own) begin
            if (w_cur_req && (r_hold < HOLD_LAST)) begin
                w_nxt_hold = r_hold + HOLD_W'(1);
            end else if (w_cur_req && !w_found) begin
                // Hold budget spent but nobody is waiting: keep the bus and
                // restart the budget.
                w_nxt_hold = '0;
            end else begin
                w_nxt_last = r_sel;
                if (w_found) begin
                    w_nxt_grant = 4'b0001 << w_idx;
                    w_nxt_sel   = w_idx;
                end else begin
                    // Go idle; the select keeps pointing at the old owner.
                    w_nxt_grant = 4'b0000;
                end
            end
        end else if (w_found) begin
            w_nxt_grant = 4'b0001 << w_idx;
            w_nxt_sel   = w_idx;
        end
    end

    // Output decision: capture only while the owner still requests.
    assign w_capture = |(r_grant & req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_q <= w_mux_y;
            end
        end
    end

    assign grant = r_grant;
    assign A0    = r_sel[0];
    assign A1    = r_sel[1];
    assign Q     = r_q;
    assign valid = r_valid;
endmodule
